// File: rtl/path_share_sequencer_if.sv
// Bundle between requesters, the shared launch/capture path and the sequencer.
// The sequencer takes the slave side; requesters plus the path flops take master.
interface path_share_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  launch_en;
  logic [WIDTH-1:0]      launch_d;
  logic                  capture_en;
  logic [WIDTH-1:0]      capture_q;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_data;
  logic                  busy;

  modport master (
    output req, req_data, capture_q,
    input  gnt, launch_en, launch_d, capture_en, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req, req_data, capture_q,
    output gnt, launch_en, launch_d, capture_en, resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/path_share_sequencer.sv
// Round-robin sequencer for one shared launch -> delay chain -> capture path,
// strobing the capture flop MCP_CYCLES clocks after launch.
module path_share_sequencer #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 8,
  parameter int MCP_CYCLES = 2,
  parameter int IDW        = $clog2(NREQ)
) (
  input logic clk,
  input logic rst,
  path_share_sequencer_if.slave bus
);
  localparam int CW = (MCP_CYCLES > 1) ? $clog2(MCP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, SETTLE, RESP} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   winner_reg;
  logic [CW-1:0]    count_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             launch_en_reg;
  logic [WIDTH-1:0] launch_d_reg;
  logic             capture_en_reg;
  logic             resp_valid_reg;
  logic [IDW-1:0]   resp_id_reg;
  logic [WIDTH-1:0] resp_data_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] req_words [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign req_words[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search upward from rr_ptr; iterating from the far end lets the nearest hit win.
  logic           arb_found;
  logic [IDW-1:0] arb_idx;
  int             arb_pos;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_pos   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_pos = (int'(rr_ptr_reg) + k) % NREQ;
      if (bus.req[arb_pos]) begin
        arb_found = 1'b1;
        arb_idx   = IDW'(arb_pos);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      winner_reg     <= '0;
      count_reg      <= '0;
      gnt_reg        <= '0;
      launch_en_reg  <= 1'b0;
      launch_d_reg   <= '0;
      capture_en_reg <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= '0;
      resp_data_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      gnt_reg        <= '0;
      launch_en_reg  <= 1'b0;
      capture_en_reg <= 1'b0;
      resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, RESP: begin
          if (arb_found) begin
            state_reg     <= LAUNCH;
            winner_reg    <= arb_idx;
            gnt_reg       <= NREQ'(1) << arb_idx;
            launch_en_reg <= 1'b1;
            launch_d_reg  <= req_words[arb_idx];
            busy_reg      <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        LAUNCH: begin
          rr_ptr_reg <= (winner_reg == IDW'(NREQ - 1)) ? '0 : winner_reg + IDW'(1);
          count_reg  <= CW'(MCP_CYCLES - 1);
          if (MCP_CYCLES == 1) begin
            state_reg      <= CAPTURE;
            capture_en_reg <= 1'b1;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // Leaving on the cycle the counter steps to zero lands capture_en
          // exactly MCP_CYCLES clocks after launch_en.
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg      <= CAPTURE;
            capture_en_reg <= 1'b1;
          end
        end
        CAPTURE: begin
          state_reg <= SETTLE;
        end
        SETTLE: begin
          resp_data_reg  <= bus.capture_q;
          resp_id_reg    <= winner_reg;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.launch_en  = launch_en_reg;
  assign bus.launch_d   = launch_d_reg;
  assign bus.capture_en = capture_en_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_id    = resp_id_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_path_share_sequencer.sv
// Bench: two sequencers (MCP_CYCLES=2 and 1) with loopback path flops, a
// transaction-level expectation model and a pinned table of literal values.
`timescale 1ns/1ps
module tb_path_share_sequencer;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int NI    = 2;
  localparam int DEPTH = 256;
  localparam int LAST  = 170;

  localparam int S_GNT = 0, S_LE = 1, S_LD = 2, S_CE = 3;
  localparam int S_RV = 4, S_RID = 5, S_RD = 6, S_BUSY = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       want [NI];
  logic [NREQ*WIDTH-1:0] words;
  logic                  hold;
  int                    cyc = 0;
  int                    n_chk = 0;
  int                    n_fail = 0;

  path_share_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus [NI] ();

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [WIDTH-1:0] launch_q  = '0;
      logic [WIDTH-1:0] capture_q = '0;
      assign bus[gi].req       = want[gi];
      assign bus[gi].req_data  = words;
      assign bus[gi].capture_q = capture_q;
      always @(posedge clk) begin
        if (bus[gi].launch_en)  launch_q  <= bus[gi].launch_d;
        if (bus[gi].capture_en) capture_q <= launch_q;
      end
      path_share_sequencer #(
        .NREQ(NREQ), .WIDTH(WIDTH), .MCP_CYCLES((gi == 0) ? 2 : 1)
      ) u_dut (
        .clk(clk), .rst(rst), .bus(bus[gi])
      );
    end
  endgenerate

  // Expected outputs per instance per cycle, filled in ahead by whole transactions.
  logic [NREQ-1:0]  e_gnt  [NI][DEPTH];
  bit               e_le   [NI][DEPTH];
  logic [WIDTH-1:0] e_ld   [NI][DEPTH];
  bit               e_ce   [NI][DEPTH];
  bit               e_rv   [NI][DEPTH];
  bit               e_busy [NI][DEPTH];
  logic [IDW-1:0]   e_rid  [NI][DEPTH];
  logic [WIDTH-1:0] e_rd   [NI][DEPTH];
  bit               upd    [NI][DEPTH];
  logic [IDW-1:0]   u_rid  [NI][DEPTH];
  logic [WIDTH-1:0] u_rd   [NI][DEPTH];
  int               rr       [NI];
  int               next_arb [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      rr[i] = 0;
      next_arb[i] = 0;
      for (int j = 0; j < DEPTH; j++) begin
        e_gnt[i][j] = '0; e_le[i][j] = 0; e_ld[i][j] = '0; e_ce[i][j] = 0;
        e_rv[i][j] = 0; e_busy[i][j] = 0; e_rid[i][j] = '0; e_rd[i][j] = '0;
        upd[i][j] = 0; u_rid[i][j] = '0; u_rd[i][j] = '0;
      end
    end
  end

  always @(posedge clk) begin
    int k;
    k = cyc;
    for (int i = 0; i < NI; i++) begin
      int mcp;
      int w;
      logic [WIDTH-1:0] d;
      mcp = (i == 0) ? 2 : 1;
      w = -1;
      d = '0;
      if (rst) begin
        for (int j = k + 1; j < DEPTH; j++) begin
          e_gnt[i][j] = '0; e_le[i][j] = 0; e_ce[i][j] = 0;
          e_rv[i][j] = 0; e_busy[i][j] = 0; upd[i][j] = 0;
        end
        rr[i] = 0;
        next_arb[i] = k + 1;
        e_rid[i][k+1] = '0;
        e_rd[i][k+1] = '0;
      end else begin
        if (k >= next_arb[i]) begin
          for (int s = 0; s < NREQ; s++)
            if (w < 0 && want[i][(rr[i] + s) % NREQ]) w = (rr[i] + s) % NREQ;
          if (w >= 0) begin
            d = words[w*WIDTH +: WIDTH];
            e_gnt[i][k+1] = NREQ'(1) << w;
            e_le[i][k+1] = 1;
            e_ld[i][k+1] = d;
            e_ce[i][k+1+mcp] = 1;
            e_rv[i][k+3+mcp] = 1;
            for (int j = k + 1; j <= k + 3 + mcp; j++) e_busy[i][j] = 1;
            upd[i][k+3+mcp] = 1;
            u_rid[i][k+3+mcp] = IDW'(w);
            u_rd[i][k+3+mcp] = d;
            rr[i] = (w + 1) % NREQ;
            next_arb[i] = k + 3 + mcp;
          end
        end
        e_rid[i][k+1] = upd[i][k+1] ? u_rid[i][k+1] : e_rid[i][k];
        e_rd[i][k+1]  = upd[i][k+1] ? u_rd[i][k+1]  : e_rd[i][k];
      end
    end
    cyc = k + 1;
  end

  typedef struct {
    int         c;
    int         i;
    int         s;
    logic [7:0] v;
  } pin_t;
  pin_t pins[$];

  task automatic pin(input int c, input int i, input int s, input logic [7:0] v);
    pin_t p;
    p.c = c; p.i = i; p.s = s; p.v = v;
    pins.push_back(p);
  endtask

  function automatic string sig_name(input int s);
    case (s)
      S_GNT:   return "gnt";
      S_LE:    return "launch_en";
      S_LD:    return "launch_d";
      S_CE:    return "capture_en";
      S_RV:    return "resp_valid";
      S_RID:   return "resp_id";
      S_RD:    return "resp_data";
      default: return "busy";
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: actual %0h required %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [NREQ-1:0] g, input logic le,
                          input logic [WIDTH-1:0] ld, input logic ce, input logic rv,
                          input logic [IDW-1:0] rid, input logic [WIDTH-1:0] rd,
                          input logic b);
    logic [7:0] act [8];
    act[S_GNT] = 8'(g);  act[S_LE] = 8'(le);  act[S_LD] = 8'(ld);  act[S_CE] = 8'(ce);
    act[S_RV] = 8'(rv);  act[S_RID] = 8'(rid); act[S_RD] = 8'(rd); act[S_BUSY] = 8'(b);
    chk("gnt", i, act[S_GNT], 8'(e_gnt[i][cyc]));
    chk("launch_en", i, act[S_LE], 8'(e_le[i][cyc]));
    if (e_le[i][cyc]) chk("launch_d", i, act[S_LD], 8'(e_ld[i][cyc]));
    chk("capture_en", i, act[S_CE], 8'(e_ce[i][cyc]));
    chk("resp_valid", i, act[S_RV], 8'(e_rv[i][cyc]));
    chk("resp_id", i, act[S_RID], 8'(e_rid[i][cyc]));
    chk("resp_data", i, act[S_RD], 8'(e_rd[i][cyc]));
    chk("busy", i, act[S_BUSY], 8'(e_busy[i][cyc]));
    foreach (pins[p])
      if (pins[p].c == cyc && pins[p].i == i)
        chk({"pin_", sig_name(pins[p].s)}, i, act[pins[p].s], pins[p].v);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < DEPTH) begin
      cmp_inst(0, bus[0].gnt, bus[0].launch_en, bus[0].launch_d, bus[0].capture_en,
               bus[0].resp_valid, bus[0].resp_id, bus[0].resp_data, bus[0].busy);
      cmp_inst(1, bus[1].gnt, bus[1].launch_en, bus[1].launch_d, bus[1].capture_en,
               bus[1].resp_valid, bus[1].resp_id, bus[1].resp_data, bus[1].busy);
    end
  end

  initial begin
    for (int s = 0; s < 8; s++) pin(2, 0, s, 8'h00);
    // single request, MCP=2 / MCP=1
    pin(6, 0, S_GNT, 8'h01);  pin(6, 0, S_LD, 8'hA5);  pin(7, 0, S_CE, 8'h00);
    pin(8, 0, S_CE, 8'h01);   pin(9, 0, S_RV, 8'h00);  pin(10, 0, S_RV, 8'h01);
    pin(10, 0, S_RID, 8'h00); pin(10, 0, S_RD, 8'hA5); pin(7, 0, S_BUSY, 8'h01);
    pin(7, 1, S_CE, 8'h01);   pin(9, 1, S_RV, 8'h01);  pin(9, 1, S_RD, 8'hA5);
    // two simultaneous requests
    pin(21, 0, S_GNT, 8'h02); pin(25, 0, S_GNT, 8'h00); pin(26, 0, S_GNT, 8'h04);
    pin(25, 0, S_RID, 8'h01); pin(30, 0, S_RID, 8'h02); pin(30, 0, S_RD, 8'h22);
    // request raised during another requester's launch
    pin(41, 0, S_GNT, 8'h01); pin(45, 0, S_GNT, 8'h00); pin(45, 0, S_RV, 8'h01);
    pin(46, 0, S_GNT, 8'h02); pin(50, 0, S_RD, 8'h77);
    // MCP=1 on id 3
    pin(61, 1, S_GNT, 8'h08); pin(61, 1, S_CE, 8'h00); pin(62, 1, S_CE, 8'h01);
    pin(63, 1, S_RV, 8'h00);  pin(64, 1, S_RV, 8'h01); pin(64, 1, S_RD, 8'h3C);
    pin(64, 1, S_RID, 8'h03);
    // reset during WAIT
    pin(81, 0, S_GNT, 8'h01); pin(83, 0, S_CE, 8'h00); pin(83, 0, S_BUSY, 8'h00);
    pin(83, 0, S_RD, 8'h00);  pin(85, 0, S_RV, 8'h00);
    pin(87, 0, S_GNT, 8'h01); pin(92, 0, S_GNT, 8'h04);
    // all four held
    for (int n = 0; n < 8; n++) pin(111 + 5*n, 0, S_GNT, 8'(1 << (n % 4)));
    pin(113, 0, S_GNT, 8'h00);

    want[0] = '0; want[1] = '0; words = '0; hold = 1'b0; rst = 1'b1;
    while (cyc < LAST) begin
      @(negedge clk);
      if (!hold) begin
        want[0] = want[0] & ~bus[0].gnt;
        want[1] = want[1] & ~bus[1].gnt;
      end
      case (cyc)
        3:   rst = 1'b0;
        5:   begin words[7:0] = 8'hA5; want[0] |= 4'b0001; want[1] |= 4'b0001; end
        20:  begin
               words[15:8] = 8'h11; words[23:16] = 8'h22;
               want[0] |= 4'b0110; want[1] |= 4'b0110;
             end
        40:  begin words[7:0] = 8'h5A; want[0] |= 4'b0001; want[1] |= 4'b0001; end
        41:  begin words[15:8] = 8'h77; want[0] |= 4'b0010; want[1] |= 4'b0010; end
        60:  begin words[31:24] = 8'h3C; want[0] |= 4'b1000; want[1] |= 4'b1000; end
        80:  begin words[7:0] = 8'h99; want[0] |= 4'b0001; want[1] |= 4'b0001; end
        82:  rst = 1'b1;
        83:  rst = 1'b0;
        86:  begin
               words[7:0] = 8'h0F; words[23:16] = 8'h2F;
               want[0] |= 4'b0101; want[1] |= 4'b0101;
             end
        105: rst = 1'b1;
        106: rst = 1'b0;
        110: begin hold = 1'b1; words = 32'h13121110; want[0] = 4'b1111; want[1] = 4'b1111; end
        148: begin hold = 1'b0; want[0] = '0; want[1] = '0; end
        default: ;
      endcase
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
